// File: rtl/fetch_align_pkg.sv
// Shared types and helpers for the halfword-granular instruction fetch FIFO.
package fetch_align_pkg;

    localparam int HALF_W  = 16;
    localparam int INSTR_W = 32;

    typedef logic [HALF_W-1:0] half_t;

    // RISC-V: a halfword whose two LSBs are not 2'b11 starts a 16-bit instruction.
    function automatic logic is_compressed(input half_t h);
        return h[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_align_mem.sv
// CAP x 16-bit register file: two write ports for a full fetch word,
// two combinational read ports for the head instruction.
module fetch_align_mem
    import fetch_align_pkg::*;
#(
    parameter  int CAP   = 8,
    localparam int PTR_W = $clog2(CAP)
) (
    input  logic             clk_i,
    input  logic             we0_i,
    input  logic [PTR_W-1:0] waddr0_i,
    input  half_t            wdata0_i,
    input  logic             we1_i,
    input  logic [PTR_W-1:0] waddr1_i,
    input  half_t            wdata1_i,
    input  logic [PTR_W-1:0] raddr0_i,
    input  logic [PTR_W-1:0] raddr1_i,
    output half_t            rdata0_o,
    output half_t            rdata1_o
);

    half_t mem_q [CAP];

    // Halfword writes; the two ports always target adjacent, distinct entries.
    // NOTE: no reset on the array -- occupancy is tracked by the count, so stale
    // entries are never observed, and a reset here would block RAM/flop-array mapping.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (we0_i) mem_q[waddr0_i] <= wdata0_i;
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fetch_align_fifo.sv
// Instruction-fetch FIFO storing 32-bit fetch words at halfword granularity and
// presenting one realigned (16- or 32-bit) RISC-V instruction per handshake.
module fetch_align_fifo
    import fetch_align_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(2*DEPTH+1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               push_valid_i,
    output logic               push_ready_o,
    input  logic [INSTR_W-1:0] push_data_i,
    input  logic               push_offset_i,
    output logic               pop_valid_o,
    input  logic               pop_ready_i,
    output logic [INSTR_W-1:0] pop_data_o,
    output logic               pop_compressed_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam int CAP   = 2 * DEPTH;
    localparam int PTR_W = $clog2(CAP);

    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    half_t            h0, h1;
    logic             head_compressed;
    logic             push_fire, pop_fire;
    logic [1:0]       push_step, pop_step;

    fetch_align_mem #(.CAP(CAP)) u_mem (
        .clk_i    (clk_i),
        .we0_i    (push_fire && !flush_i),
        .waddr0_i (wr_ptr_q),
        .wdata0_i (push_offset_i ? push_data_i[31:16] : push_data_i[15:0]),
        .we1_i    (push_fire && !flush_i && !push_offset_i),
        .waddr1_i (wr_ptr_q + PTR_W'(1)),
        .wdata1_i (push_data_i[31:16]),
        .raddr0_i (rd_ptr_q),
        .raddr1_i (rd_ptr_q + PTR_W'(1)),
        .rdata0_o (h0),
        .rdata1_o (h1)
    );

    assign head_compressed = is_compressed(h0);

    // Conservative: always leave room for a full word, whatever the offset.
    assign push_ready_o = !rst_i && (count_q <= CNT_W'(CAP - 2));
    assign push_fire    = push_valid_i && push_ready_o;
    assign pop_fire     = pop_valid_o && pop_ready_i;
    assign push_step    = push_fire ? (push_offset_i ? 2'd1 : 2'd2) : 2'd0;
    assign pop_step     = pop_fire ? (head_compressed ? 2'd1 : 2'd2) : 2'd0;
    assign count_o      = count_q;

    // Head decode: a 32-bit instruction needs both of its halfwords present.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        pop_valid_o      = 1'b0;
        pop_compressed_o = 1'b0;
        pop_data_o       = '0;
        if (count_q != '0) begin
            pop_compressed_o = head_compressed;
            if (head_compressed) begin
                pop_valid_o = 1'b1;
                pop_data_o  = {{(INSTR_W-HALF_W){1'b0}}, h0};
            end else if (count_q >= CNT_W'(2)) begin
                pop_valid_o = 1'b1;
                pop_data_o  = {h1, h0};
            end
        end
    end

    // Pointer and occupancy update; flush wins over any concurrent push/pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(push_step);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop_step);
            count_q  <= count_q + CNT_W'(push_step) - CNT_W'(pop_step);
        end
    end

endmodule

// File: tb/tb_fetch_align_fifo.sv
// Self-checking bench for fetch_align_fifo: directed scenarios plus random
// traffic, all compared against a halfword-queue reference model.
module tb_fetch_align_fifo;

    localparam int DEPTH = 4;
    localparam int CAP   = 2 * DEPTH;
    localparam int CNT_W = $clog2(2*DEPTH+1);

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic             push_valid_i;
    logic             push_ready_o;
    logic [31:0]      push_data_i;
    logic             push_offset_i;
    logic             pop_valid_o;
    logic             pop_ready_i;
    logic [31:0]      pop_data_o;
    logic             pop_compressed_o;
    logic [CNT_W-1:0] count_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the stored halfwords in arrival order.
    logic [15:0] q[$];
    logic        e_valid, e_comp, e_ready;
    logic [31:0] e_data;

    fetch_align_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .push_valid_i     (push_valid_i),
        .push_ready_o     (push_ready_o),
        .push_data_i      (push_data_i),
        .push_offset_i    (push_offset_i),
        .pop_valid_o      (pop_valid_o),
        .pop_ready_i      (pop_ready_i),
        .pop_data_o       (pop_data_o),
        .pop_compressed_o (pop_compressed_o),
        .count_o          (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_outputs();
        int n;
        n       = q.size();
        e_valid = 1'b0;
        e_comp  = 1'b0;
        e_data  = 32'h0;
        e_ready = !rst_i && (CAP - n >= 2);
        if (n >= 1) begin
            e_comp = (q[0][1:0] != 2'b11);
            if (e_comp) begin
                e_valid = 1'b1;
                e_data  = {16'h0, q[0]};
            end else if (n >= 2) begin
                e_valid = 1'b1;
                e_data  = {q[1], q[0]};
            end
        end
    endtask

    task automatic drive(input logic pv, input logic [31:0] d, input logic off,
                         input logic pr, input logic fl);
        push_valid_i  = pv;
        push_data_i   = d;
        push_offset_i = off;
        pop_ready_i   = pr;
        flush_i       = fl;
    endtask

    task automatic check_outputs();
        #1;
        model_outputs();
        check("count",      32'(count_o),          32'(q.size()));
        check("push_ready", 32'(push_ready_o),     32'(e_ready));
        check("pop_valid",  32'(pop_valid_o),      32'(e_valid));
        check("compressed", 32'(pop_compressed_o), 32'(e_comp));
        check("pop_data",   pop_data_o,            e_data);
    endtask

    // Apply the clock edge to the model, then to the DUT.
    task automatic tick();
        model_outputs();
        if (rst_i || flush_i) begin
            q.delete();
        end else begin
            if (e_valid && pop_ready_i) begin
                void'(q.pop_front());
                if (!e_comp) void'(q.pop_front());
            end
            if (push_valid_i && e_ready) begin
                if (push_offset_i) begin
                    q.push_back(push_data_i[31:16]);
                end else begin
                    q.push_back(push_data_i[15:0]);
                    q.push_back(push_data_i[31:16]);
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic cycle(input logic pv, input logic [31:0] d, input logic off,
                         input logic pr, input logic fl);
        drive(pv, d, off, pr, fl);
        check_outputs();
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * CAP && q.size() != 0; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_outputs();
        check("drain_empty", 32'(count_o), 32'h0);
    endtask

    function automatic logic [15:0] rand_half();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        return h;
    endfunction

    initial begin
        rst_i = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_outputs();
        tick();
        tick();
        rst_i = 1'b0;

        // Two compressed halves, popped one by one.
        cycle(1'b1, 32'h0000_4501, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_outputs();
        check("tp1_data", pop_data_o, 32'h0000_4501);
        check("tp1_count2", 32'(count_o), 32'd2);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_outputs();
        check("tp1_count1", 32'(count_o), 32'd1);
        check("tp1_valid0000", 32'(pop_valid_o), 32'd1);
        tick();
        drain();

        // Misaligned branch target: upper half only, completed by the next word.
        cycle(1'b1, 32'h0093_0113, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_0093, 1'b0, 1'b0, 1'b0);
        check_outputs();
        check("tp2_partial_valid", 32'(pop_valid_o), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_outputs();
        check("tp2_data", pop_data_o, 32'h0093_0093);
        check("tp2_count", 32'(count_o), 32'd3);
        drain();

        // Straddling 32-bit instruction, repeated until the pointers wrap.
        for (int r = 0; r < 4; r++) begin
            cycle(1'b1, 32'h0513_4501, 1'b0, 1'b0, 1'b0);
            cycle(1'b1, 32'h4501_0000, 1'b0, 1'b1, 1'b0);
            drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            check_outputs();
            check("tp3_straddle", pop_data_o, 32'h0000_0513);
            tick();
            drain();
        end

        // Fill to capacity, then pop with a refused same-cycle push.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        check_outputs();
        check("tp4_full_count", 32'(count_o), 32'd8);
        check("tp4_full_ready", 32'(push_ready_o), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_outputs();
        check("tp4_count7", 32'(count_o), 32'd7);
        check("tp4_ready7", 32'(push_ready_o), 32'd0);
        drain();

        // Steady state with 32-bit instructions.
        cycle(1'b1, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
            check_outputs();
            check("tp5_count", 32'(count_o), 32'd2);
            tick();
        end
        drain();

        // Flush beats a concurrent push and pop.
        cycle(1'b1, 32'h1234_5601, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0513_0513, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_outputs();
        check("tp6_flush_count", 32'(count_o), 32'd0);
        check("tp6_flush_valid", 32'(pop_valid_o), 32'd0);

        // Asynchronous reset mid-stream clears outputs before the next edge.
        cycle(1'b1, 32'h4501_4501, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0001_0001, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_valid", 32'(pop_valid_o), 32'd0);
        check("rst_data", pop_data_o, 32'h0);
        check("rst_comp", 32'(pop_compressed_o), 32'd0);
        check("rst_ready", 32'(push_ready_o), 32'd0);
        q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  {rand_half(), rand_half()},
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 63) == 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
